// File: rtl/iomem_miss_unit.sv
// iomem_miss_unit: cache miss engine issuing optional write-back then refill/uncached beat on iomem.
module iomem_miss_unit #(
  parameter int BLOCK_SIZE = 128,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int NUMS_BYTE = BLOCK_SIZE / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_uncached,
  input  logic                  req_we,
  input  logic [NUMS_BYTE-1:0]  req_wstrb,
  input  logic [BLOCK_SIZE-1:0] req_wdata,
  input  logic                  req_evict,
  input  logic [31:0]           evict_addr,
  input  logic [BLOCK_SIZE-1:0] evict_data,
  output logic                  rsp_valid,
  output logic [BLOCK_SIZE-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  iomem_valid,
  output logic [31:0]           iomem_addr,
  output logic [NUMS_BYTE-1:0]  iomem_wstrb,
  output logic [BLOCK_SIZE-1:0] iomem_wdata,
  input  logic                  iomem_ready,
  input  logic [BLOCK_SIZE-1:0] iomem_rdata
);
  typedef enum logic [2:0] {IDLE, WB, GAP, RD, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] r_addr, a_src, rd_addr;
  logic r_unc, r_we, u_src, w_src;
  logic [NUMS_BYTE-1:0] r_wstrb, rd_wstrb;
  logic [BLOCK_SIZE-1:0] r_wdata, rd_wdata;
  logic unused_ok;
  assign unused_ok = ^evict_addr[3:0];
  assign req_ready = state == IDLE;
  // RD beat fields come straight from the request when leaving IDLE, else from the latched copy
  always_comb begin
    a_src = state == IDLE ? req_addr : r_addr;
    u_src = state == IDLE ? req_uncached : r_unc;
    w_src = state == IDLE ? req_we : r_we;
    rd_addr = u_src ? a_src : {a_src[31:4], 4'h0};
    rd_wstrb = w_src ? (state == IDLE ? req_wstrb : r_wstrb) : '0;
    rd_wdata = w_src ? (state == IDLE ? req_wdata : r_wdata) : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      iomem_valid <= 1'b0;
      iomem_addr <= '0;
      iomem_wstrb <= '0;
      iomem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_data <= '0;
      r_addr <= '0;
      r_unc <= 1'b0;
      r_we <= 1'b0;
      r_wstrb <= '0;
      r_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          r_addr <= req_addr;
          r_unc <= req_uncached;
          r_we <= req_we;
          r_wstrb <= req_wstrb;
          r_wdata <= req_wdata;
          cnt <= '0;
          iomem_valid <= 1'b1;
          if (req_evict && !req_uncached) begin
            state <= WB;
            iomem_addr <= {evict_addr[31:4], 4'h0};
            iomem_wstrb <= '1;
            iomem_wdata <= evict_data;
          end else begin
            state <= RD;
            iomem_addr <= rd_addr;
            iomem_wstrb <= rd_wstrb;
            iomem_wdata <= rd_wdata;
          end
        end
        WB, RD: if (iomem_ready) begin
          iomem_valid <= 1'b0;
          if (state == WB) state <= GAP;
          else begin
            rsp_data <= iomem_rdata;
            rsp_err <= 1'b0;
            rsp_valid <= 1'b1;
            state <= RESP;
          end
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          iomem_valid <= 1'b0;
          rsp_err <= 1'b1;
          rsp_valid <= 1'b1;
          state <= RESP;
        end else cnt <= cnt + 1'b1;
        GAP: begin
          state <= RD;
          cnt <= '0;
          iomem_valid <= 1'b1;
          iomem_addr <= rd_addr;
          iomem_wstrb <= rd_wstrb;
          iomem_wdata <= rd_wdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iomem_miss_unit.sv
// tb_iomem_miss_unit: random and directed miss transactions against a transaction-level model.
module tb_iomem_miss_unit;
  localparam int TO = 20;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_uncached = 0, req_we = 0, req_evict = 0;
  logic [31:0] req_addr = 0, evict_addr = 0, iomem_addr;
  logic [15:0] req_wstrb = 0, iomem_wstrb;
  logic [127:0] req_wdata = 0, evict_data = 0, rsp_data, iomem_wdata, iomem_rdata = 0;
  logic rsp_valid, rsp_err, iomem_valid, iomem_ready = 0;
  int total = 0, bad = 0;
  time last_hi_time = 0;
  bit last_was_wb = 0;
  logic [127:0] exp_rsp = 0;

  iomem_miss_unit #(.BLOCK_SIZE(128), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_uncached(req_uncached), .req_we(req_we),
    .req_wstrb(req_wstrb), .req_wdata(req_wdata), .req_evict(req_evict),
    .evict_addr(evict_addr), .evict_data(evict_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .iomem_valid(iomem_valid),
    .iomem_addr(iomem_addr), .iomem_wstrb(iomem_wstrb), .iomem_wdata(iomem_wdata),
    .iomem_ready(iomem_ready), .iomem_rdata(iomem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int rdelay();
    return ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, TO - 1));
  endfunction

  task automatic beat(input logic [31:0] a, input logic [127:0] wd, input logic [15:0] ws,
                      input int d, input logic [127:0] rd, output bit ab);
    int n = 0, k = 0, gap;
    logic [31:0] a0;
    logic [127:0] w0;
    logic [15:0] s0;
    bit st = 1;
    while (!iomem_valid && n < 8) begin
      iomem_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    iomem_ready = 0;
    check("beat_start", iomem_valid, 1);
    gap = int'(($time - last_hi_time) / 10) - 1;
    if (last_hi_time != 0) check(last_was_wb ? "gap_wb" : "gap_min", last_was_wb ? (gap == 1) : (gap >= 2), 1);
    check("addr", iomem_addr, a);
    check("wdata", iomem_wdata, wd);
    check("wstrb", iomem_wstrb, ws);
    a0 = iomem_addr; w0 = iomem_wdata; s0 = iomem_wstrb;
    while (iomem_valid && k < 300) begin
      st &= (iomem_addr == a0) && (iomem_wdata == w0) && (iomem_wstrb == s0);
      iomem_ready = (k == d);
      iomem_rdata = (k == d) ? rd : r128();
      last_hi_time = $time;
      @(negedge clk);
      k++;
    end
    iomem_ready = 0;
    check("beat_len", k, d < TO ? d + 1 : TO);
    check("stable", st, 1);
    ab = d >= TO;
  endtask

  task automatic txn(input logic [31:0] a, input logic unc, input logic we, input logic ev,
                     input logic [31:0] ea, input logic [127:0] ed, input logic [127:0] wd,
                     input logic [15:0] ws, input int dwb, input int drd,
                     input logic [127:0] rd, input bit hold);
    int n = 0;
    bit ab = 0;
    req_addr = a; req_uncached = unc; req_we = we; req_evict = ev;
    evict_addr = ea; evict_data = ed; req_wdata = wd; req_wstrb = ws; req_valid = 1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", req_ready, 1);
    @(negedge clk);
    check("busy", req_ready, 0);
    req_valid = hold;
    req_addr = $urandom; req_uncached = 1'($urandom); req_we = 1'($urandom); req_evict = 1'($urandom);
    evict_addr = $urandom; evict_data = r128(); req_wdata = r128(); req_wstrb = 16'($urandom);
    if (ev && !unc) begin
      beat({ea[31:4], 4'h0}, ed, 16'hFFFF, dwb, r128(), ab);
      last_was_wb = 1;
      if (!ab) check("gap_rsp", rsp_valid, 0);
    end
    if (!ab) begin
      beat(unc ? a : {a[31:4], 4'h0}, we ? wd : 128'h0, we ? ws : 16'h0, drd, rd, ab);
      if (!ab) exp_rsp = rd;
    end
    last_was_wb = 0;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, ab);
    check("rsp_data", rsp_data, exp_rsp);
    check("valid_resp", iomem_valid, 0);
    @(negedge clk);
    check("rsp_once", rsp_valid, 0);
    check("idle_ready", req_ready, 1);
    check("valid_idle", iomem_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", iomem_valid, 0);
    check("rst_wstrb", iomem_wstrb, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_ready", req_ready, 1);
    rst = 0;
    @(negedge clk);
    txn(32'h4000_0124, 0, 0, 0, 0, 0, r128(), 16'hFFFF, 0, 16, r128(), 0);
    txn(32'h4000_0B10, 0, 0, 1, 32'h4000_0A30, r128(), 0, 0, 3, 2, r128(), 0);
    txn(32'h3000_0004, 1, 0, 0, 0, 0, 0, 0, 0, 0, {96'h0, 32'h1234_5678}, 0);
    check("timer_word", rsp_data[31:0], 32'h1234_5678);
    txn(32'h4000_0200, 0, 0, 1, 32'h4000_0300, r128(), 0, 0, TO + 5, 0, r128(), 0);
    txn(32'h4000_0400, 0, 1, 0, 0, 0, r128(), 16'h00F0, 0, TO + 9, r128(), 0);
    txn(32'h4000_0440, 0, 0, 0, 0, 0, 0, 0, 0, 1, r128(), 0);
    txn(32'h5000_0007, 1, 1, 1, 32'h6000_0000, r128(), r128(), 16'h8001, 0, 4, r128(), 0);
    txn(32'h4000_1000, 0, 1, 1, 32'h4000_2000, r128(), r128(), 16'h0F0F, 5, 3, r128(), 1);
    txn(32'h4000_1010, 0, 1, 0, 0, 0, r128(), 16'h3C3C, 0, 6, r128(), 0);
    req_addr = 32'h4000_0800; req_uncached = 0; req_we = 1; req_wstrb = 16'hAAAA;
    req_wdata = r128(); req_evict = 0; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    for (int k = 0; k < 5; k++) begin
      check("pre_rst_valid", iomem_valid, 1);
      if (k < 4) @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    check("mid_rst_valid", iomem_valid, 0);
    check("mid_rst_rsp", rsp_valid, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_wstrb", iomem_wstrb, 0);
    check("mid_rst_data", rsp_data, 0);
    rst = 0;
    exp_rsp = 0;
    @(negedge clk);
    check("post_rst_rsp", rsp_valid, 0);
    check("post_rst_valid", iomem_valid, 0);
    for (int i = 0; i < 40; i++)
      txn($urandom, $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), $urandom, r128(),
          r128(), 16'($urandom), rdelay(), rdelay(), r128(), i < 39 ? 1'($urandom) : 1'b0);
    req_valid = 0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
